// File: rtl/width_decoder.sv
// RISC-V load/store funct3 -> memory access-width code, with a combinational result
// for same-cycle use and a stall/flush-aware registered copy for the next stage.
module width_decoder #(
  parameter logic [2:0] DEFAULT_WIDTH = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] funct3,
  input  logic       WidthOp,
  input  logic       en,
  input  logic       flush,
  output logic [2:0] WidthSrc,
  output logic       WidthIllegal,
  output logic [2:0] WidthSrcQ,
  output logic       WidthIllegalQ
);

  // Width code: bit2 = zero-extend, bits[1:0] = 00 word / 01 byte / 10 half.
  // The result is packed as {illegal, width[2:0]}.
  function automatic logic [3:0] decode_width(input logic [2:0] f3, input logic op);
    logic [3:0] res;
    if (op) begin
      case (f3)
        3'b010:  res = {1'b0, 3'b000};
        3'b001:  res = {1'b0, 3'b010};
        3'b000:  res = {1'b0, 3'b001};
        3'b101:  res = {1'b0, 3'b110};
        3'b100:  res = {1'b0, 3'b101};
        default: res = {1'b1, DEFAULT_WIDTH};
      endcase
    end else begin
      res = {1'b0, DEFAULT_WIDTH};
    end
    return res;
  endfunction

  logic [3:0] w_dec;
  logic [2:0] r_width_src;
  logic       r_width_illegal;

  // Zero-latency decode of the current instruction fields.
  always_comb begin
    w_dec = decode_width(funct3, WidthOp);
  end

  assign WidthSrc     = w_dec[2:0];
  assign WidthIllegal = w_dec[3];

  // Pipeline register: flush inserts a bubble and wins over the stall enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_width_src     <= 3'b000;
      r_width_illegal <= 1'b0;
    end else if (flush) begin
      r_width_src     <= 3'b000;
      r_width_illegal <= 1'b0;
    end else if (en) begin
      r_width_src     <= w_dec[2:0];
      r_width_illegal <= w_dec[3];
    end else begin
      r_width_src     <= r_width_src;
      r_width_illegal <= r_width_illegal;
    end
  end

  assign WidthSrcQ     = r_width_src;
  assign WidthIllegalQ = r_width_illegal;

endmodule

// File: tb/tb_width_decoder.sv
// Self-checking bench for width_decoder: table-driven decode vectors, directed
// reset/stall/flush sequences, and a randomized run against a delayed reference model.
module tb_width_decoder;

  logic       clk;
  logic       reset;
  logic [2:0] funct3;
  logic       WidthOp;
  logic       en;
  logic       flush;
  logic [2:0] WidthSrc;
  logic       WidthIllegal;
  logic [2:0] WidthSrcQ;
  logic       WidthIllegalQ;

  int n_vec;
  int n_err;

  width_decoder #(.DEFAULT_WIDTH(3'b000)) dut (
    .clk(clk), .reset(reset), .funct3(funct3), .WidthOp(WidthOp), .en(en), .flush(flush),
    .WidthSrc(WidthSrc), .WidthIllegal(WidthIllegal),
    .WidthSrcQ(WidthSrcQ), .WidthIllegalQ(WidthIllegalQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [2:0] f3;
    logic [2:0] exp_src;
    logic       exp_ill;
  } vec_t;

  vec_t vecs[16];

  // Reference table returning {illegal, width}.
  function automatic logic [3:0] ref_decode(input logic op, input logic [2:0] f3);
    if (!op) return 4'b0000;
    case (f3)
      3'd2:    return 4'b0000;
      3'd1:    return 4'b0010;
      3'd0:    return 4'b0001;
      3'd5:    return 4'b0110;
      3'd4:    return 4'b0101;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  logic [3:0] model_q;
  logic [3:0] dec;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; funct3 = 3'd0; WidthOp = 1'b0; en = 1'b0; flush = 1'b0;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b0, 3'(i), 3'b000, 1'b0};
    vecs[8]  = '{1'b1, 3'b010, 3'b000, 1'b0};
    vecs[9]  = '{1'b1, 3'b001, 3'b010, 1'b0};
    vecs[10] = '{1'b1, 3'b000, 3'b001, 1'b0};
    vecs[11] = '{1'b1, 3'b101, 3'b110, 1'b0};
    vecs[12] = '{1'b1, 3'b100, 3'b101, 1'b0};
    vecs[13] = '{1'b1, 3'b011, 3'b000, 1'b1};
    vecs[14] = '{1'b1, 3'b110, 3'b000, 1'b1};
    vecs[15] = '{1'b1, 3'b111, 3'b000, 1'b1};

    #12;
    chk("reset_q", {WidthIllegalQ, WidthSrcQ}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;

    // Table sweep: combinational result now, registered copy after the next edge.
    for (int i = 0; i < 16; i++) begin
      WidthOp = vecs[i].op;
      funct3  = vecs[i].f3;
      #1;
      chk($sformatf("comb_v%0d", i), {WidthIllegal, WidthSrc}, {vecs[i].exp_ill, vecs[i].exp_src});
      @(negedge clk);
      chk($sformatf("reg_v%0d", i), {WidthIllegalQ, WidthSrcQ}, {vecs[i].exp_ill, vecs[i].exp_src});
    end

    // Asynchronous reset mid-cycle while holding 110.
    WidthOp = 1'b1; funct3 = 3'b101;
    @(negedge clk);
    chk("pre_reset_q", {WidthIllegalQ, WidthSrcQ}, 4'b0110);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_q", {WidthIllegalQ, WidthSrcQ}, 4'b0000);
    chk("comb_in_reset", {WidthIllegal, WidthSrc}, 4'b0110);
    @(negedge clk);
    chk("reset_held_q", {WidthIllegalQ, WidthSrcQ}, 4'b0000);
    reset = 1'b0; funct3 = 3'b100;
    @(negedge clk);
    chk("post_reset_cap", {WidthIllegalQ, WidthSrcQ}, 4'b0101);

    // Stall hold, then flush overriding en.
    funct3 = 3'b001;
    @(negedge clk);
    chk("load_010", {WidthIllegalQ, WidthSrcQ}, 4'b0010);
    en = 1'b0; funct3 = 3'b101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", k), {WidthIllegalQ, WidthSrcQ}, 4'b0010);
    end
    funct3 = 3'b111;
    en = 1'b1;
    @(negedge clk);
    chk("load_illegal", {WidthIllegalQ, WidthSrcQ}, 4'b1000);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_q", {WidthIllegalQ, WidthSrcQ}, 4'b0000);
    flush = 1'b0;

    // Randomized run against a one-cycle-delayed model.
    model_q = 4'b0000;
    for (int c = 0; c < 1000; c++) begin
      WidthOp = 1'($urandom_range(1, 0));
      funct3  = 3'($urandom_range(7, 0));
      en      = ($urandom_range(3, 0) != 0);
      flush   = ($urandom_range(7, 0) == 0);
      dec = ref_decode(WidthOp, funct3);
      #1;
      chk($sformatf("rand_comb_%0d", c), {WidthIllegal, WidthSrc}, dec);
      if (flush)   model_q = 4'b0000;
      else if (en) model_q = dec;
      @(negedge clk);
      chk($sformatf("rand_reg_%0d", c), {WidthIllegalQ, WidthSrcQ}, model_q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
